// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and active-low segment constants for the HEX display path
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Index 0..9 are digit glyphs (GFEDCBA, active-low); 10..15 decode to blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    {6{SEG_BLANK}},
    7'h18, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_digit_decoder.sv
// rtl/seg_digit_decoder.sv - one BCD nibble to an active-low seven-segment code
module seg_digit_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : SEG_TABLE[bcd_i];

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - iterative double-dabble binary-to-BCD converter driving four HEX digits
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX0
);

  localparam int SW = 16 + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    shift_q, shift_d, adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             blz_q, blz_d;
  logic             over_q, over_d;
  logic             done_q, done_d;
  logic [3:0][6:0]  hex_q, hex_d;
  logic [3:0][6:0]  dec_seg;
  logic [3:0][3:0]  bcd;
  logic [3:0]       blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      blz_q   <= 1'b0;
      over_q  <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= {4{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      blz_q   <= blz_d;
      over_q  <= over_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    blz_d   = blz_q;
    over_d  = over_q;
    done_d  = 1'b0;
    hex_d   = hex_q;
    adj     = shift_q;
    for (int k = 0; k < 4; k++) begin
      if (adj[WIDTH+4*k +: 4] >= 4'd5) adj[WIDTH+4*k +: 4] = adj[WIDTH+4*k +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = {{16{1'b0}}, in_value};
          cnt_d   = '0;
          blz_d   = blank_lz;
          over_d  = in_value > MAX_V;
          state_d = (in_value > MAX_V) ? LATCH : SHIFT;
        end
      end
      SHIFT: begin
        shift_d = adj << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = LATCH;
      end
      LATCH: begin
        hex_d   = over_q ? {4{SEG_DASH}} : dec_seg;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Blanking cascades from the top digit; the units digit always shows.
  always_comb begin
    for (int k = 0; k < 4; k++) bcd[k] = shift_q[WIDTH+4*k +: 4];
    blank[3] = blz_q && (bcd[3] == 4'd0);
    blank[2] = blank[3] && (bcd[2] == 4'd0);
    blank[1] = blank[2] && (bcd[1] == 4'd0);
    blank[0] = 1'b0;
  end

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg_digit_decoder u_dec (
      .bcd_i   (bcd[g]),
      .blank_i (blank[g]),
      .seg_o   (dec_seg[g])
    );
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign HEX3     = hex_q[3];
  assign HEX2     = hex_q[2];
  assign HEX1     = hex_q[1];
  assign HEX0     = hex_q[0];

endmodule
